// File: rtl/instr_fetch_if.sv
// Instruction-memory bus for instr_fetch: one request outstanding at a time,
// with the response returned on a one-cycle mem_valid strobe.
interface instr_fetch_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              mem_valid;

  // Fetcher side: issues requests, receives data.
  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_valid
  );

  // Memory side: receives requests, returns data.
  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_valid
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetches one- and two-word instructions from instruction memory
// and presents them to the control unit with a valid/stall handshake.
// Two-word instructions have opcode[6:4] = 3'b010; the second word is the imm.
// Optional feature macro: IFETCH_HALT_EN -- when defined, HLT (7'b1100001)
// parks the fetcher in HALT until a flush; when undefined, HLT issues as an
// ordinary one-word instruction and halted is tied low.
module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_if.master        mem,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    flush_pc,
  input  logic                 stall,
  output logic [6:0]           opcode,
  output logic [8:0]           operand,
  output logic [15:0]          imm,
  output logic                 instr_valid,
  output logic                 halted
);

`ifdef IFETCH_HALT_EN
  typedef enum logic [2:0] {FETCH1, FETCH2, ISSUE, DRAIN, HALT} state_t;
  localparam logic [6:0] OP_HLT = 7'b1100001;
`else
  typedef enum logic [2:0] {FETCH1, FETCH2, ISSUE, DRAIN} state_t;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [6:0]        r_opcode;
  logic [8:0]        r_operand;
  logic [15:0]       r_imm;
  logic              r_valid;
  logic              r_run;
  logic              w_mem_req;
  logic              w_outstanding;
  logic              w_two_word;

  assign w_two_word    = (mem.mem_rdata[15:13] == 3'b010);
  assign w_outstanding = w_mem_req || (r_state == DRAIN);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FETCH1;
    else        r_state <= w_next;
  end

  // Next-state logic; flush overrides every other event.
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = (w_outstanding && !mem.mem_valid) ? DRAIN : FETCH1;
    end else begin
      case (r_state)
        FETCH1: if (mem.mem_valid) w_next = w_two_word ? FETCH2 : ISSUE;
        FETCH2: if (mem.mem_valid) w_next = ISSUE;
`ifdef IFETCH_HALT_EN
        ISSUE:  if (!stall) w_next = (r_opcode == OP_HLT) ? HALT : FETCH1;
        HALT:   w_next = HALT;
`else
        ISSUE:  if (!stall) w_next = FETCH1;
`endif
        DRAIN:  if (mem.mem_valid) w_next = FETCH1;
        default: w_next = FETCH1;
      endcase
    end
  end

  // Output decode: request only in the fetch states, and never before the
  // first clock edge after reset release.
  always_comb begin
    w_mem_req = r_run && ((r_state == FETCH1) || (r_state == FETCH2));
`ifdef IFETCH_HALT_EN
    halted    = (r_state == HALT);
`else
    halted    = 1'b0;
`endif
  end

  // Marks the first clock edge after reset so mem_req stays low until then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // Datapath: pc, latched instruction fields and the issue-valid flag.
  // FETCH1 accepts mem_valid even before r_run so a stale response that
  // follows reset is taken as the RESET_PC word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_opcode  <= '0;
      r_operand <= '0;
      r_imm     <= '0;
      r_valid   <= 1'b0;
    end else if (flush) begin
      r_pc      <= flush_pc;
      r_opcode  <= '0;
      r_operand <= '0;
      r_imm     <= '0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        FETCH1: begin
          if (mem.mem_valid) begin
            r_opcode  <= mem.mem_rdata[15:9];
            r_operand <= mem.mem_rdata[8:0];
            r_imm     <= '0;
            r_pc      <= r_pc + ADDR_W'(1);
            r_valid   <= !w_two_word;
          end
        end
        FETCH2: begin
          if (mem.mem_valid) begin
            r_imm   <= mem.mem_rdata;
            r_pc    <= r_pc + ADDR_W'(1);
            r_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (!stall) r_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req  = w_mem_req;
  assign mem.mem_addr = r_pc;
  assign opcode       = r_opcode;
  assign operand      = r_operand;
  assign imm          = r_imm;
  assign instr_valid  = r_valid;

endmodule
